// File: rtl/pci_conf_scan_ctrl.sv
// pci_conf_scan_ctrl: walks the device numbers of one PCI bus. For each device it issues
// a single configuration read and records which devices return a valid Vendor ID.
// Bus 0 gets Type 0 addresses (devices 0..20); every other bus gets Type 1 addresses
// (devices 0..31).
//
// Ports:
//   wb_clk_in        clock
//   reset_in         synchronous, active-high reset
//   scan_start_in    single-cycle scan command; honoured only when idle
//   bus_num_in       bus to scan; latched when a scan is accepted
//   cfg_req_out      configuration read request; held until a response or timeout
//   cfg_addr_out     configuration-cycle address; zero while no request is pending
//   cfg_ack_in       read completed; cfg_rdata_in is valid in the same cycle
//   cfg_abort_in     master abort; takes priority over cfg_ack_in
//   cfg_rdata_in     read data; only bits [15:0] (Vendor ID) are used
//   busy_out         scan in progress
//   done_out         one-cycle pulse when a scan ends
//   dev_present_out  bit d set when device d responded with a valid Vendor ID
//   present_cnt_out  number of devices found
module pci_conf_scan_ctrl #(
    parameter logic [5:0]  REG_OFFSET = 6'd0,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        wb_clk_in,
    input  logic        reset_in,
    input  logic        scan_start_in,
    input  logic [7:0]  bus_num_in,
    output logic        cfg_req_out,
    output logic [31:0] cfg_addr_out,
    input  logic        cfg_ack_in,
    input  logic        cfg_abort_in,
    input  logic [31:0] cfg_rdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] dev_present_out,
    output logic [5:0]  present_cnt_out
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone} state_e;

    // The ISSUE cycle already has cfg_req_out high, so the WAIT phase gives up after
    // TIMEOUT-1 cycles; the request is then high for exactly TIMEOUT cycles.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 2);

    state_e      state_q, state_d;
    logic [7:0]  bus_q, bus_d;
    logic [4:0]  dev_q, dev_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] present_q, present_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [4:0]  dev_last;
    logic [31:0] addr;
    logic        unused_rdata;

    assign unused_rdata = ^cfg_rdata_in[31:16];

    // Bus 0 only decodes IDSEL for devices 0..20.
    assign dev_last = (bus_q == 8'd0) ? 5'd20 : 5'd31;

    always_comb begin
        if (bus_q == 8'd0) begin
            addr = {16'h0000, dev_q, 3'b000, REG_OFFSET, 2'b00};
        end else begin
            addr = {8'h00, bus_q, dev_q, 3'b000, REG_OFFSET, 2'b01};
        end
    end

    always_ff @(posedge wb_clk_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            bus_q     <= 8'd0;
            dev_q     <= 5'd0;
            tmo_q     <= 8'd0;
            present_q <= 32'd0;
            cnt_q     <= 6'd0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            dev_q     <= dev_d;
            tmo_q     <= tmo_d;
            present_q <= present_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        dev_d     = dev_q;
        tmo_d     = tmo_q;
        present_d = present_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (scan_start_in) begin
                    bus_d     = bus_num_in;
                    present_d = 32'd0;
                    cnt_d     = 6'd0;
                    dev_d     = 5'd0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                if (cfg_abort_in) begin
                    state_d = StNext;
                end else if (cfg_ack_in) begin
                    // All-ones Vendor ID means nothing answered the read.
                    if (cfg_rdata_in[15:0] != 16'hFFFF) begin
                        present_d[dev_q] = 1'b1;
                        cnt_d            = cnt_q + 6'd1;
                    end
                    state_d = StNext;
                end else if (tmo_q == TmoLast) begin
                    state_d = StNext;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StNext: begin
                // Compare before incrementing so device 31 never wraps to 0.
                if (dev_q == dev_last) begin
                    state_d = StDone;
                end else begin
                    dev_d   = dev_q + 5'd1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cfg_req_out     = (state_q == StIssue) || (state_q == StWait);
    assign cfg_addr_out    = cfg_req_out ? addr : 32'd0;
    assign busy_out        = (state_q == StIssue) || (state_q == StWait) || (state_q == StNext);
    assign done_out        = (state_q == StDone);
    assign dev_present_out = present_q;
    assign present_cnt_out = cnt_q;

endmodule

// File: tb/tb_pci_conf_scan_ctrl.sv
module tb_pci_conf_scan_ctrl;

    localparam int unsigned TMO  = 16;
    localparam logic [5:0]  ROFF = 6'd0;

    localparam int KAbort = 0;
    localparam int KAck   = 1;
    localparam int KNone  = 2;
    localparam int KBoth  = 3;

    logic        clk;
    logic        reset_in;
    logic        scan_start;
    logic [7:0]  bus_num;
    logic        cfg_req;
    logic [31:0] cfg_addr;
    logic        cfg_ack;
    logic        cfg_abort;
    logic [31:0] cfg_rdata;
    logic        busy;
    logic        done;
    logic [31:0] dev_present;
    logic [5:0]  present_cnt;

    int ncmp;
    int nfail;

    // Per-device response plan: kind, WAIT cycle of the response (1-based), read data.
    int          kind [32];
    int          dly  [32];
    logic [31:0] rdat [32];

    pci_conf_scan_ctrl #(
        .REG_OFFSET (ROFF),
        .TIMEOUT    (TMO)
    ) dut (
        .wb_clk_in       (clk),
        .reset_in        (reset_in),
        .scan_start_in   (scan_start),
        .bus_num_in      (bus_num),
        .cfg_req_out     (cfg_req),
        .cfg_addr_out    (cfg_addr),
        .cfg_ack_in      (cfg_ack),
        .cfg_abort_in    (cfg_abort),
        .cfg_rdata_in    (cfg_rdata),
        .busy_out        (busy),
        .done_out        (done),
        .dev_present_out (dev_present),
        .present_cnt_out (present_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address built arithmetically from the field positions.
    function automatic logic [31:0] ref_addr(input logic [7:0] bus, input int dev);
        int unsigned a;
        a = dev * 2048 + ROFF * 4;
        if (bus != 8'd0) a = a + bus * 65536 + 1;
        return a;
    endfunction

    task automatic plan_all(input int k);
        for (int d = 0; d < 32; d++) begin
            kind[d] = k;
            dly[d]  = $urandom_range(1, TMO - 1);
            rdat[d] = $urandom;
        end
    endtask

    task automatic plan_random();
        for (int d = 0; d < 32; d++) begin
            kind[d] = $urandom_range(0, 3);
            dly[d]  = $urandom_range(1, TMO - 1);
            rdat[d] = $urandom;
            if ($urandom_range(0, 3) == 0) rdat[d][15:0] = 16'hFFFF;
        end
    endtask

    // Runs one scan. start_dev: device during whose request an extra scan command is
    // pulsed. reset_dev: device during whose WAIT reset is applied (scan then abandoned).
    task automatic do_scan(input logic [7:0] bus, input int start_dev, input int reset_dev);
        int          limit;
        int          nreq;
        int          k;
        int          exp_hi;
        int          n;
        int          exp_cnt;
        logic [31:0] exp_present;
        bit          seen_done;
        bit          addr_bad;
        bit          extra_req;

        limit       = (bus == 8'd0) ? 21 : 32;
        exp_present = 32'd0;
        exp_cnt     = 0;
        nreq        = 0;
        seen_done   = 1'b0;

        @(negedge clk);
        scan_start = 1'b1;
        bus_num    = bus;
        @(negedge clk);
        scan_start = 1'b0;
        bus_num    = 8'($urandom);
        chk("req_latency", cfg_req, 1);
        chk("busy_rise", busy, 1);

        for (int d = 0; d < limit; d++) begin
            n = 0;
            while (!cfg_req && n < 4) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("req_seen_d%0d", d), cfg_req, 1);
            if (!cfg_req) return;
            nreq++;
            chk($sformatf("addr_d%0d", d), cfg_addr, ref_addr(bus, d));
            exp_hi   = (kind[d] == KNone) ? TMO : dly[d] + 1;
            addr_bad = 1'b0;
            k        = 1;
            forever begin
                if (d == start_dev && k == 1) begin
                    scan_start = 1'b1;
                    bus_num    = 8'h77;
                end
                if (d == reset_dev && k == 2) reset_in = 1'b1;
                if (kind[d] != KNone && k == dly[d] + 1) begin
                    cfg_ack   = (kind[d] == KAck) || (kind[d] == KBoth);
                    cfg_abort = (kind[d] == KAbort) || (kind[d] == KBoth);
                    cfg_rdata = rdat[d];
                end
                @(negedge clk);
                scan_start = 1'b0;
                cfg_ack    = 1'b0;
                cfg_abort  = 1'b0;
                cfg_rdata  = $urandom;
                if (d == reset_dev && k == 2) begin
                    reset_in = 1'b0;
                    chk("rst_req", cfg_req, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_present", dev_present, 0);
                    chk("rst_cnt", present_cnt, 0);
                    chk("rst_addr", cfg_addr, 0);
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                    chk("rst_stay_idle", busy, 0);
                    return;
                end
                if (done) seen_done = 1'b1;
                if (!cfg_req || k > TMO + 2) break;
                if (cfg_addr !== ref_addr(bus, d)) addr_bad = 1'b1;
                k++;
            end
            chk($sformatf("hold_d%0d", d), k, exp_hi);
            chk($sformatf("addr_stable_d%0d", d), addr_bad, 0);
            if (kind[d] == KAck && rdat[d][15:0] != 16'hFFFF) begin
                exp_present[d] = 1'b1;
                exp_cnt++;
            end
            // Stray response while no request is pending.
            if ($urandom_range(0, 1) == 1) begin
                cfg_ack   = 1'b1;
                cfg_rdata = 32'h0000_1234;
                @(negedge clk);
                cfg_ack   = 1'b0;
            end
        end

        n = 0;
        while (!done && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("no_early_done", seen_done, 0);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 0);
        chk("nreq", nreq, limit);
        chk("present", dev_present, exp_present);
        chk("present_cnt", present_cnt, exp_cnt);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        extra_req = 1'b0;
        repeat (4) begin
            if (cfg_req || busy) extra_req = 1'b1;
            @(negedge clk);
        end
        chk("no_extra_req", extra_req, 0);
        chk("present_hold", dev_present, exp_present);
        chk("cnt_hold", present_cnt, exp_cnt);
    endtask

    initial begin
        ncmp       = 0;
        nfail      = 0;
        reset_in   = 1'b1;
        scan_start = 1'b0;
        bus_num    = 8'd0;
        cfg_ack    = 1'b0;
        cfg_abort  = 1'b0;
        cfg_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        chk("reset_req", cfg_req, 0);
        chk("reset_addr", cfg_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_present", dev_present, 0);
        chk("reset_cnt", present_cnt, 0);

        // Bus 0, every request aborted one cycle after it rises.
        plan_all(KAbort);
        for (int d = 0; d < 32; d++) dly[d] = 1;
        do_scan(8'd0, -1, -1);

        // Bus 0, devices 3 and 20 present.
        plan_all(KAbort);
        kind[3]  = KAck;
        rdat[3]  = 32'h1234_8086;
        kind[20] = KAck;
        rdat[20] = 32'h0001_10EE;
        do_scan(8'd0, -1, -1);

        // Invalid Vendor ID and ack+abort collision.
        plan_all(KAbort);
        kind[5] = KAck;
        rdat[5] = 32'h0000_FFFF;
        kind[6] = KBoth;
        rdat[6] = 32'h0000_8086;
        do_scan(8'd0, -1, -1);

        // Bus 5, nothing responds: every request times out.
        plan_all(KNone);
        do_scan(8'h05, -1, -1);

        // Extra start during dev 2, reset during dev 4 WAIT, then a fresh scan.
        plan_random();
        kind[1] = KAck;
        rdat[1] = 32'h0000_8086;
        kind[2] = KAbort;
        kind[4] = KNone;
        do_scan(8'd0, 2, 4);
        plan_random();
        do_scan(8'd0, -1, -1);

        // Bus 1, every device present.
        plan_all(KAck);
        for (int d = 0; d < 32; d++) rdat[d] = 32'h0000_10EE;
        do_scan(8'h01, -1, -1);

        // Randomised scans.
        for (int i = 0; i < 4; i++) begin
            plan_random();
            do_scan(($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
